// File: rtl/mult_pipe_pkg.sv
// rtl/mult_pipe_pkg.sv - shared types and default constants for the lane multiplier pipe
package mult_pipe_pkg;

   typedef enum logic {
      RND_TRUNC   = 1'b0,
      RND_NEAREST = 1'b1
   } rnd_mode_e;

   localparam int DEF_DATA_W = 16;
   localparam int DEF_FRAC_W = 15;
   localparam int DEF_LANES  = 4;
   localparam int DEF_STAGES = 3;
   localparam int DEF_ID_W   = 4;

endpackage

// File: rtl/mult_lane_rs.sv
// rtl/mult_lane_rs.sv - one lane of signed fixed-point multiply, optional round-half-up, saturate
module mult_lane_rs
   import mult_pipe_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int FRAC_W = DEF_FRAC_W
) (
   input  logic signed [DATA_W-1:0] a_i,
   input  logic signed [DATA_W-1:0] b_i,
   input  logic                     rnd_i,
   output logic        [DATA_W-1:0] z_o,
   output logic                     sat_o
);

   localparam int PW = 2 * DATA_W;
   localparam logic signed [PW-1:0] Z_MAX = {{(DATA_W + 1){1'b0}}, {(DATA_W - 1){1'b1}}};
   localparam logic signed [PW-1:0] Z_MIN = {{(DATA_W + 1){1'b1}}, {(DATA_W - 1){1'b0}}};

   logic signed [PW-1:0] a_ext;
   logic signed [PW-1:0] b_ext;
   logic signed [PW-1:0] prod;
   logic signed [PW-1:0] bias;
   logic signed [PW-1:0] shifted;

   // Full-width product cannot overflow, so the bias add is safe even for -1 * -1.
   always_comb begin
      a_ext   = {{DATA_W{a_i[DATA_W-1]}}, a_i};
      b_ext   = {{DATA_W{b_i[DATA_W-1]}}, b_i};
      prod    = a_ext * b_ext;
      bias    = (rnd_mode_e'(rnd_i) == RND_NEAREST) ? (PW'(1) << (FRAC_W - 1)) : '0;
      shifted = (prod + bias) >>> FRAC_W;
      z_o     = shifted[DATA_W-1:0];
      sat_o   = 1'b0;
      if (shifted > Z_MAX) begin
         z_o   = Z_MAX[DATA_W-1:0];
         sat_o = 1'b1;
      end else if (shifted < Z_MIN) begin
         z_o   = Z_MIN[DATA_W-1:0];
         sat_o = 1'b1;
      end
   end

endmodule

// File: rtl/mult_pipe_lanes.sv
// rtl/mult_pipe_lanes.sv - multi-lane multiply pipeline with bubble collapsing; MULT_PIPE_CENSUS_EN adds occupancy counter
module mult_pipe_lanes
   import mult_pipe_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int FRAC_W = DEF_FRAC_W,
   parameter int LANES  = DEF_LANES,
   parameter int STAGES = DEF_STAGES,
   parameter int ID_W   = DEF_ID_W
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic [LANES*DATA_W-1:0]      in_a,
   input  logic [LANES*DATA_W-1:0]      in_b,
   input  logic                         in_rnd,
   input  logic [ID_W-1:0]              in_id,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic [LANES*DATA_W-1:0]      out_z,
   output logic [LANES-1:0]             out_sat,
   output logic [ID_W-1:0]              out_id,
   output logic [$clog2(STAGES+1)-1:0]  census,
   output logic                         pipe_full
);

   localparam int VW = LANES * DATA_W;
   localparam int CW = $clog2(STAGES + 1);

   logic [VW-1:0]    lane_z;
   logic [LANES-1:0] lane_sat;

   logic [VW-1:0]    z_q   [STAGES];
   logic [LANES-1:0] sat_q [STAGES];
   logic [ID_W-1:0]  id_q  [STAGES];
   logic [STAGES-1:0] valid_q;
   logic [STAGES-1:0] adv;
   logic              adv_run;

   for (genvar k = 0; k < LANES; k++) begin : g_lane
      mult_lane_rs #(
         .DATA_W (DATA_W),
         .FRAC_W (FRAC_W)
      ) u_lane (
         .a_i   (in_a[k*DATA_W +: DATA_W]),
         .b_i   (in_b[k*DATA_W +: DATA_W]),
         .rnd_i (in_rnd),
         .z_o   (lane_z[k*DATA_W +: DATA_W]),
         .sat_o (lane_sat[k])
      );
   end

   // A stage may move if any stage at or after it is empty, or the output is taken.
   always_comb begin
      adv     = '0;
      adv_run = out_ready;
      for (int i = STAGES - 1; i >= 0; i--) begin
         adv_run = adv_run || !valid_q[i];
         adv[i]  = adv_run;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q <= '0;
         for (int i = 0; i < STAGES; i++) begin
            z_q[i]   <= '0;
            sat_q[i] <= '0;
            id_q[i]  <= '0;
         end
      end else begin
         if (adv[0]) begin
            valid_q[0] <= in_valid;
            if (in_valid) begin
               z_q[0]   <= lane_z;
               sat_q[0] <= lane_sat;
               id_q[0]  <= in_id;
            end
         end
         for (int i = 1; i < STAGES; i++) begin
            if (adv[i]) begin
               valid_q[i] <= valid_q[i-1];
               if (valid_q[i-1]) begin
                  z_q[i]   <= z_q[i-1];
                  sat_q[i] <= sat_q[i-1];
                  id_q[i]  <= id_q[i-1];
               end
            end
         end
      end
   end

   assign in_ready  = !valid_q[0] || adv[0];
   assign out_valid = valid_q[STAGES-1];
   assign out_z     = z_q[STAGES-1];
   assign out_sat   = sat_q[STAGES-1];
   assign out_id    = id_q[STAGES-1];

`ifdef MULT_PIPE_CENSUS_EN
   logic [CW-1:0] census_q;
   logic [CW-1:0] census_d;
   logic          accept;
   logic          emit;

   assign accept = in_valid && in_ready;
   assign emit   = out_valid && out_ready;

   always_comb begin
      census_d = census_q;
      if (accept && !emit) begin
         census_d = census_q + CW'(1);
      end else if (!accept && emit) begin
         census_d = census_q - CW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         census_q <= '0;
      end else begin
         census_q <= census_d;
      end
   end

   assign census    = census_q;
   assign pipe_full = (census_q == CW'(STAGES));
`else
   assign census    = '0;
   assign pipe_full = 1'b0;
`endif

endmodule

// File: doc/mult_pipe_lanes.md
MULT_PIPE_LANES -- requirements
Module: mult_pipe_lanes

Interface
REQ-001 SHALL have parameter DATA_W, default 16: signed fixed-point operand/result width per lane.
REQ-002 SHALL have parameter FRAC_W, default 15: fractional bits of operands and result; legal range 1..DATA_W-1.
REQ-003 SHALL have parameter LANES, default 4: independent multiply channels sharing one handshake.
REQ-004 SHALL have parameter STAGES, default 3: pipeline depth, legal range 1..16.
REQ-005 SHALL have parameter ID_W, default 4: width of the tag carried alongside each beat.
REQ-006 SHALL have port clk, input, 1: the single clock; all logic on rising edge.
REQ-007 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-008 SHALL have port in_valid, input, 1: input beat present.
REQ-009 SHALL have port in_ready, output, 1: block accepts the beat this cycle.
REQ-010 SHALL have port in_a, input, LANES*DATA_W: multiplicand, lane k at bits [k*DATA_W +: DATA_W].
REQ-011 SHALL have port in_b, input, LANES*DATA_W: multiplier, same packing.
REQ-012 SHALL have port in_rnd, input, 1: 0 truncate, 1 round-half-up; per beat.
REQ-013 SHALL have port in_id, input, ID_W: tag travelling with the beat.
REQ-014 SHALL have port out_valid, output, 1: result beat present.
REQ-015 SHALL have port out_ready, input, 1: downstream accepts the result.
REQ-016 SHALL have port out_z, output, LANES*DATA_W: results, same packing.
REQ-017 SHALL have port out_sat, output, LANES: per-lane saturation flag.
REQ-018 SHALL have port out_id, output, ID_W: tag of the presented result.
REQ-019 SHALL have port census, output, $clog2(STAGES+1): number of occupied stages.
REQ-020 SHALL have port pipe_full, output, 1: all STAGES stages occupied.

Function
REQ-021 SHALL transfer a beat on in_valid&&in_ready (input) and out_valid&&out_ready (output).
REQ-022 SHALL compute per lane p = a*b (2*DATA_W signed); if rnd, p += 2^(FRAC_W-1); z = p >>> FRAC_W (arithmetic).
REQ-023 SHALL saturate z to [-2^(DATA_W-1), 2^(DATA_W-1)-1] and set that lane's out_sat when clamped.
REQ-024 SHALL present a result exactly STAGES cycles after acceptance when out_ready is held high.
REQ-025 SHALL sustain one beat per cycle with out_ready high; results in acceptance order with unmodified tag.
REQ-026 SHALL let stage i advance when stage i+1 is empty or advancing (bubble collapsing); last stage advances on out_ready or when empty.
REQ-027 SHALL drive in_ready = !valid[0] || advance[0], combinationally dependent on out_ready.
REQ-028 SHALL hold out_z/out_sat/out_id/out_valid stable while out_valid && !out_ready.
REQ-029 SHALL accept and emit in the same cycle when full with out_ready high (no throughput loss).
REQ-030 SHALL never drop or duplicate a beat under any out_ready pattern.

Reset
REQ-031 SHALL, on rst high at a clock edge, clear all stage valid bits and data/tag registers to 0 regardless of in-flight beats.
REQ-032 SHALL output during and after reset: out_valid=0, out_z=0, out_sat=0, out_id=0, census=0, pipe_full=0, in_ready=1 once rst is low.
REQ-033 SHALL discard beats presented while rst is high.

Configuration
REQ-034 SHALL, with MULT_PIPE_CENSUS_EN defined, maintain census as registered occupancy (+1 accept, -1 emit, unchanged on both) and pipe_full = (census==STAGES).
REQ-035 SHALL, without MULT_PIPE_CENSUS_EN, tie census and pipe_full to 0 and contain no occupancy counter.

Structure
REQ-036 SHALL place rounding-mode typedef (RND_TRUNC=0, RND_NEAREST=1) and default parameter constants in package mult_pipe_pkg.
REQ-037 SHALL implement per-lane multiply/round/saturate in combinational sub-module mult_lane_rs, instantiated LANES times.

Verification
REQ-038 Q1.15, rnd=0, a=0x4000, b=0x4000, out_ready=1 -> out_z=0x2000, sat=0, after exactly 3 cycles.
REQ-039 a=0x8000, b=0x8000 -> out_z=0x7FFF, out_sat=1; a=0x8000, b=0x7FFF -> 0x8001, sat=0.
REQ-040 a=0x0001, b=0x4000: rnd=0 -> 0x0000; rnd=1 -> 0x0001; a=0xFFFF, b=0x4000, rnd=1 -> 0x0000.
REQ-041 Stream 10 beats ids 0..9, out_ready low 5 cycles -> in_ready low after 3 accepted, census=3, pipe_full=1; release -> ids 0..9 in order, none lost.
REQ-042 Random in_valid/out_ready 10k beats LANES=4 -> scoreboard match, outputs stable while stalled.
REQ-043 rst high with 2 beats in flight -> next cycle out_valid=0, census=0; no stale beat emitted afterward.
